// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one-bit-per-cycle shift-add multiply or restoring divide into HI/LO.
// Optional feature macro: SIGNED_MULDIV_EN (op[1] selects signed MULT/DIV when defined).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_next;

  logic [CNT_W-1:0] count;
  logic             is_div, div_zero;
  logic [WIDTH-1:0] a_raw, addend, acc_hi, acc_lo;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] hi_step, lo_step, res_hi, res_lo;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH+1:0] div_diff;
  logic             unused_bits;

`ifdef SIGNED_MULDIV_EN
  logic sign_a, sign_b, neg_main, neg_rem;
  assign sign_a      = op[1] & operand_a[WIDTH-1];
  assign sign_b      = op[1] & operand_b[WIDTH-1];
  assign a_mag       = sign_a ? -operand_a : operand_a;
  assign b_mag       = sign_b ? -operand_b : operand_b;
  assign unused_bits = div_diff[WIDTH];
`else
  assign a_mag       = operand_a;
  assign b_mag       = operand_b;
  assign unused_bits = ^{div_diff[WIDTH], op[1]};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (count == LAST) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // One iteration of either algorithm; acc_hi/acc_lo hold {carry-free acc, multiplier} or {rem, quot}.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, addend} : '0);
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, addend};
    if (is_div) begin
      if (!div_diff[WIDTH+1]) begin
        hi_step = div_diff[WIDTH-1:0];
        lo_step = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = div_sh[WIDTH-1:0];
        lo_step = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Final result as committed on the last iteration edge.
  always_comb begin
    res_hi = hi_step;
    res_lo = lo_step;
`ifdef SIGNED_MULDIV_EN
    if (is_div) begin
      if (neg_main) res_lo = -lo_step;
      if (neg_rem)  res_hi = -hi_step;
    end else if (neg_main) begin
      {res_hi, res_lo} = -{hi_step, lo_step};
    end
`endif
    if (is_div && div_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count       <= '0;
      is_div      <= 1'b0;
      div_zero    <= 1'b0;
      a_raw       <= '0;
      addend      <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
`ifdef SIGNED_MULDIV_EN
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div      <= op[0];
            div_zero    <= (operand_b == '0);
            a_raw       <= operand_a;
            acc_hi      <= '0;
            acc_lo      <= op[0] ? a_mag : b_mag;
            addend      <= op[0] ? b_mag : a_mag;
            count       <= '0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_MULDIV_EN
            neg_main    <= sign_a ^ sign_b;
            neg_rem     <= sign_a;
`endif
          end else begin
            if (mthi) hi <= write_data;
            if (mtlo) lo <= write_data;
          end
        end
        S_RUN: begin
          acc_hi <= hi_step;
          acc_lo <= lo_step;
          count  <= count + 1'b1;
          if (count == LAST) begin
            hi          <= res_hi;
            lo          <= res_lo;
            div_by_zero <= is_div & div_zero;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_muldiv_unit;
  localparam int W = 32;

  logic          clock;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  operand_a, operand_b, write_data;
  logic          mthi, mtlo;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .mthi(mthi), .mtlo(mtlo), .write_data(write_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference result {div_by_zero, hi, lo} from plain arithmetic.
  function automatic logic [64:0] expect_result(input logic [1:0] o, input logic [31:0] a,
                                                input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, q, r;
    bit          sgn;
    sgn = 1'b0;
`ifdef SIGNED_MULDIV_EN
    sgn = o[1];
`endif
    sa = $signed(a);
    sb = $signed(b);
    if (!o[0]) begin
      if (sgn) p = sa * sb;
      else     p = {32'd0, a} * {32'd0, b};
      return {1'b0, p};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
    return {1'b0, a % b, a / b};
  endfunction

  // Transaction-level model: phase 0 idle, 1..W computing, W+1 result-ready cycle.
  int          m_phase;
  logic [31:0] m_hi, m_lo;
  logic        m_dbz;
  logic [64:0] pend;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_hi    <= '0;
      m_lo    <= '0;
      m_dbz   <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        pend    <= expect_result(op, operand_a, operand_b);
        m_dbz   <= 1'b0;
        m_phase <= 1;
      end else begin
        if (mthi) m_hi <= write_data;
        if (mtlo) m_lo <= write_data;
      end
    end else if (m_phase < W) begin
      m_phase <= m_phase + 1;
    end else if (m_phase == W) begin
      m_hi    <= pend[63:32];
      m_lo    <= pend[31:0];
      m_dbz   <= pend[64];
      m_phase <= W + 1;
    end else begin
      m_phase <= 0;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("busy", busy, (m_phase >= 1 && m_phase <= W));
      check("done", done, (m_phase == W + 1));
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("div_by_zero", div_by_zero, m_dbz);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clock);
    start = 1'b0; op = ~o; operand_a = ~a; operand_b = b ^ 32'hA5A5_5A5A;
  endtask

  task automatic wait_done(output int bc);
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      if (busy) bc++;
      @(negedge clock);
    end
    check("done_seen", done, 1'b1);
  endtask

  logic [1:0]  t_op [9] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
  logic [31:0] t_a  [9] = '{32'h1234_5678, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
                            32'h8000_0000, 32'd0, 32'h8000_0000, 32'd7};
  logic [31:0] t_b  [9] = '{32'h9ABC_DEF0, 32'd10, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h0001_0000, 32'd0, 32'h8000_0000, 32'hFFFF_FFFE};

  initial begin
    int bc;
    reset = 1'b1; start = 1'b0; op = 2'd0; operand_a = '0; operand_b = '0;
    mthi = 1'b0; mtlo = 1'b0; write_data = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;

    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc);
    check("multu_max_latency", bc, 32);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);

    issue(2'd1, 32'd100, 32'd7);
    wait_done(bc);
    check("divu_busy_cycles", bc, 32);
    check("divu_100_7_lo", lo, 32'd14);
    check("divu_100_7_hi", hi, 32'd2);
    check("divu_100_7_dbz", div_by_zero, 1'b0);

    issue(2'd1, 32'd5, 32'd0);
    wait_done(bc);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'd5);
    check("divz_flag", div_by_zero, 1'b1);
    repeat (4) @(negedge clock);
    check("divz_flag_held", div_by_zero, 1'b1);

    @(negedge clock);
    mthi = 1'b1; write_data = 32'hDEAD_BEEF;
    @(negedge clock);
    mthi = 1'b0; mtlo = 1'b1; write_data = 32'h0BAD_F00D;
    @(negedge clock);
    mtlo = 1'b0;
    check("mthi_idle", hi, 32'hDEAD_BEEF);
    check("mtlo_idle", lo, 32'h0BAD_F00D);

    @(negedge clock);
    start = 1'b1; op = 2'd0; operand_a = 32'd2; operand_b = 32'd3;
    mthi = 1'b1; mtlo = 1'b1; write_data = 32'h5555_AAAA;
    @(negedge clock);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    wait_done(bc);
    check("start_wins_hi", hi, 32'd0);
    check("start_wins_lo", lo, 32'd6);

    issue(2'd0, 32'd3, 32'd4);
    repeat (8) @(negedge clock);
    start = 1'b1; op = 2'd1; operand_a = 32'd100; operand_b = 32'd7;
    mthi = 1'b1; write_data = 32'h1234_ABCD;
    @(negedge clock);
    start = 1'b0; mthi = 1'b0;
    wait_done(bc);
    check("ignored_start_hi", hi, 32'd0);
    check("ignored_start_lo", lo, 32'd12);

    for (int i = 0; i < 9; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(bc);
    end

`ifdef SIGNED_MULDIV_EN
    issue(2'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(bc);
    check("div_m7_2_lo", lo, 32'hFFFF_FFFD);
    check("div_m7_2_hi", hi, 32'hFFFF_FFFF);
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(bc);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);
    issue(2'd3, 32'hFFFF_FFF9, 32'd0);
    wait_done(bc);
    check("sdivz_lo", lo, 32'hFFFF_FFFF);
    check("sdivz_hi", hi, 32'hFFFF_FFF9);
    issue(2'd2, 32'hFFFF_FFFD, 32'd5);
    wait_done(bc);
    check("mult_m3_5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    issue(2'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(bc);
    check("op1_ignored_div_lo", lo, 32'h7FFF_FFFC);
    check("op1_ignored_div_hi", hi, 32'd1);
    issue(2'd2, 32'hFFFF_FFFD, 32'd5);
    wait_done(bc);
    check("op1_ignored_mul", {hi, lo}, 64'h0000_0004_FFFF_FFF1);
`endif

    issue(2'd1, 32'd1000, 32'd7);
    repeat (15) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    issue(2'd1, 32'd9, 32'd3);
    wait_done(bc);
    check("divu_9_3_lo", lo, 32'd3);
    check("divu_9_3_hi", hi, 32'd0);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected $finish");
    $fatal(1, "watchdog");
  end
endmodule
